microsequencer: RTL
===================

// Module: microsequencer
// PURPOSE
//  Next-state stage of the microprogrammed control unit. Holds the current control state and drives it
//  into the microstore, which returns a 44-bit control word for that state.
//  From the next-state fields of that word, the condition inputs and the decoded opcode, it computes
//  and registers the next state every cycle. Includes a memory-wait watchdog.
// PARAMETERS
//  STATE_W       7    width of state number (microstore address)
//  RESET_STATE   0    state loaded on reset and for reserved modes
//  FAULT_STATE   127  state entered on watchdog timeout
//  TIMEOUT       15   max consecutive WAIT cycles without moc before fault (1..255)
// PORTS
//  clk           in   1        clock, rising edge
//  reset         in   1        asynchronous, active-low reset
//  nsel          in   3        next-state mode from microstore word
//  csel          in   2        condition select from microstore word
//  cinv          in   1        invert selected condition
//  cr            in   STATE_W  target state field from microstore word
//  decoded_state in   STATE_W  first execute state from opcode encoder
//  cond          in   1        branch condition from datapath
//  moc           in   1        memory operation complete
//  current_state out  STATE_W  registered state, feeds microstore
//  waiting       out  1        1 while in WAIT and moc low
//  bus_fault     out  1        one-cycle pulse on watchdog timeout
// BEHAVIOUR
//  - Reset (reset=0, async): current_state=RESET_STATE, wait counter=0, bus_fault=0, ret_reg=0.
//    Clears mid-wait and mid-call. First post-reset edge uses that edge's inputs.
//  - Latency: one cycle. nsel/csel/cr at edge N select current_state after edge N.
//  - Condition: sel = csel 00:cond 01:moc 10:0 11:1. Then ctrue = sel ^ cinv.
//  - nsel modes (state+1 wraps 2^STATE_W-1 -> 0):
//    000 DECODE  next=decoded_state
//    001 JUMP    next=cr
//    010 INCR    next=current_state+1
//    011 BRANCH  next = ctrue ? cr : current_state+1
//    100 WAIT    moc=1: next=current_state+1, counter clears.
//                moc=0: hold, counter+1, waiting=1.
//    101/110     see CONFIGURATION
//    111         reserved: next=RESET_STATE
//  - Watchdog: in WAIT with moc=0 and counter==TIMEOUT-1 at the edge: next=FAULT_STATE,
//    bus_fault=1 for exactly that following cycle, counter clears.
//  - moc=1 on the timeout edge itself: moc wins, normal advance, no fault.
//  - Counter clears whenever nsel!=WAIT; it never accumulates across separate waits.
//  - waiting is combinational: (nsel==100)&&!moc. bus_fault is registered.
// CONFIGURATION
//  MSEQ_RETURN_EN defined:
//    101 CALL    ret_reg<=current_state+1, next=cr
//    110 RETURN  next=ret_reg
//    Single-level return register; a nested CALL overwrites it.
//  MSEQ_RETURN_EN undefined:
//    101/110 behave as reserved (next=RESET_STATE). No ret_reg flops exist.
// STRUCTURE
//  Shared package mseq_pkg: localparams NSEL_DECODE..NSEL_RSVD, CSEL_COND..CSEL_ONE, and the
//  STATE_W default.
//  One sub-module, mseq_cond_mux: combinational csel/cinv -> ctrue.
//  Next-state mux, incrementer, watchdog counter and ret_reg stay in microsequencer.
// TESTING
//  1. reset=0 mid-WAIT with counter=9, then release -> current_state=0, waiting resumes counting from 0.
//  2. state 0, nsel=010 x3 -> states 1,2,3. State 127, INCR -> 0 (wrap).
//  3. BRANCH cr=10, csel=00: cond=1 cinv=0 -> 10.
//     cond=1 cinv=1 -> state+1. csel=11 cinv=0 -> 10 unconditionally.
//  4. WAIT at state 5, moc low 4 cycles then high -> 5 held 4 cycles, waiting=1, then 6, bus_fault never set.
//  5. WAIT, moc low 15 edges -> FAULT_STATE=127, bus_fault=1 one cycle.
//     Repeat with moc=1 on the 15th edge -> 6, no fault.
//  6. MSEQ_RETURN_EN: CALL cr=40 from state 8 -> 40, then RETURN -> 9.
//     Without the macro, nsel=101 -> 0.

Source files
------------

// File: rtl/mseq_pkg.sv
// Shared encodings for the microsequencer: next-state modes, condition selects, default width.
package mseq_pkg;

  localparam int unsigned DEFAULT_STATE_W = 7;

  localparam logic [2:0] NSEL_DECODE = 3'b000;
  localparam logic [2:0] NSEL_JUMP   = 3'b001;
  localparam logic [2:0] NSEL_INCR   = 3'b010;
  localparam logic [2:0] NSEL_BRANCH = 3'b011;
  localparam logic [2:0] NSEL_WAIT   = 3'b100;
  localparam logic [2:0] NSEL_CALL   = 3'b101;
  localparam logic [2:0] NSEL_RETURN = 3'b110;
  localparam logic [2:0] NSEL_RSVD   = 3'b111;

  localparam logic [1:0] CSEL_COND = 2'b00;
  localparam logic [1:0] CSEL_MOC  = 2'b01;
  localparam logic [1:0] CSEL_ZERO = 2'b10;
  localparam logic [1:0] CSEL_ONE  = 2'b11;

endpackage

// File: rtl/mseq_cond_mux.sv
// Branch condition selection with optional inversion.
module mseq_cond_mux
  import mseq_pkg::*;
(
  input  logic [1:0] csel,
  input  logic       cinv,
  input  logic       cond,
  input  logic       moc,
  output logic       ctrue
);

  logic sel;

  always_comb begin
    sel = 1'b0;
    unique case (csel)
      CSEL_COND: sel = cond;
      CSEL_MOC:  sel = moc;
      CSEL_ZERO: sel = 1'b0;
      CSEL_ONE:  sel = 1'b1;
      default:   sel = 1'b0;
    endcase
    ctrue = sel ^ cinv;
  end

endmodule

// File: rtl/microsequencer.sv
// Next-state stage of the microprogrammed control unit with memory-wait watchdog.
// Define MSEQ_RETURN_EN to add single-level CALL/RETURN support.
module microsequencer
  import mseq_pkg::*;
#(
  parameter int unsigned STATE_W     = DEFAULT_STATE_W,
  parameter int unsigned RESET_STATE = 0,
  parameter int unsigned FAULT_STATE = 127,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         nsel,
  input  logic [1:0]         csel,
  input  logic               cinv,
  input  logic [STATE_W-1:0] cr,
  input  logic [STATE_W-1:0] decoded_state,
  input  logic               cond,
  input  logic               moc,
  output logic [STATE_W-1:0] current_state,
  output logic               waiting,
  output logic               bus_fault
);

  localparam int unsigned CntW = 8;
  localparam logic [STATE_W-1:0] RstState   = STATE_W'(RESET_STATE);
  localparam logic [STATE_W-1:0] FaultState = STATE_W'(FAULT_STATE);
  localparam logic [CntW-1:0]    CntLast    = CntW'(TIMEOUT - 1);

  logic [STATE_W-1:0] state_q, state_d, state_inc;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               fault_q, fault_d;
  logic               ctrue;
`ifdef MSEQ_RETURN_EN
  logic [STATE_W-1:0] ret_q, ret_d;
`endif

  mseq_cond_mux u_cond_mux (
    .csel  (csel),
    .cinv  (cinv),
    .cond  (cond),
    .moc   (moc),
    .ctrue (ctrue)
  );

  assign state_inc     = state_q + 1'b1;
  assign current_state = state_q;
  assign bus_fault     = fault_q;
  assign waiting       = (nsel == NSEL_WAIT) && !moc;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    fault_d = 1'b0;
`ifdef MSEQ_RETURN_EN
    ret_d   = ret_q;
`endif
    unique case (nsel)
      NSEL_DECODE: state_d = decoded_state;
      NSEL_JUMP:   state_d = cr;
      NSEL_INCR:   state_d = state_inc;
      NSEL_BRANCH: state_d = ctrue ? cr : state_inc;
      NSEL_WAIT: begin
        // moc on the timeout edge takes priority over the fault
        if (moc) begin
          state_d = state_inc;
        end else if (cnt_q == CntLast) begin
          state_d = FaultState;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef MSEQ_RETURN_EN
      NSEL_CALL: begin
        ret_d   = state_inc;
        state_d = cr;
      end
      NSEL_RETURN: state_d = ret_q;
      NSEL_RSVD:   state_d = RstState;
`else
      NSEL_CALL, NSEL_RETURN, NSEL_RSVD: state_d = RstState;
`endif
      default: state_d = RstState;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RstState;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

`ifdef MSEQ_RETURN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ret_q <= '0;
    else        ret_q <= ret_d;
  end
`endif

endmodule
